// File: rtl/calc_pkg.sv
// Shared definitions for the two-operand calculator sequencer:
// state encoding, button indices and the default converter timeout.
package calc_pkg;

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    CALC   = 3'd3,
    START  = 3'd4,
    WAIT   = 3'd5,
    SHOW   = 3'd6,
    ERR    = 3'd7
  } state_t;

  localparam int BTN_ENTER = 0;
  localparam int BTN_ADD   = 1;
  localparam int BTN_SUB   = 2;
  localparam int BTN_CLEAR = 3;

  localparam int CONV_TIMEOUT_DEF = 64;

  typedef struct packed {
    logic [15:0] mag;
    logic        sign;
  } alu_res_t;

endpackage

// File: rtl/calc_alu.sv
// Magnitude/sign arithmetic for the calculator; purely combinational.
// Subtraction reports |a-b| with sign set only when b is strictly larger.
module calc_alu
  import calc_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       add_sub,
  output alu_res_t   res
);

  logic [8:0] sum;
  logic [8:0] diff_ab;
  logic [8:0] diff_ba;
  logic       b_gt_a;

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    diff_ab = {1'b0, a} - {1'b0, b};
    diff_ba = {1'b0, b} - {1'b0, a};
    b_gt_a  = (b > a);
    res.mag  = 16'd0;
    res.sign = 1'b0;
    if (!add_sub) begin
      res.mag = {7'd0, sum};
    end else if (b_gt_a) begin
      res.mag  = {7'd0, diff_ba};
      res.sign = 1'b1;
    end else begin
      res.mag = {7'd0, diff_ab};
    end
  end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: collects two operands and an operation,
// computes, then hands the result to a BCD converter with a timeout.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int CONV_TIMEOUT = CONV_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  btn_pulse,
  input  logic [7:0]  sw,
  input  logic        conv_busy,
  input  logic        conv_done,
  output logic [7:0]  op_a,
  output logic [7:0]  op_b,
  output logic        add_sub,
  output logic [15:0] result,
  output logic        sign,
  output logic        conv_start,
  output logic        disp_valid,
  output logic        err,
  output logic [2:0]  state
);

  localparam int CW = $clog2(CONV_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CONV_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  op_a_q, op_a_d;
  logic [7:0]  op_b_q, op_b_d;
  logic        add_sub_q, add_sub_d;
  logic [15:0] result_q, result_d;
  logic        sign_q, sign_d;
  logic        err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        start_c;

  logic        enter;
  logic        add;
  logic        sub;
  logic        clear;
  alu_res_t    alu_res;

  assign enter = btn_pulse[BTN_ENTER];
  assign add   = btn_pulse[BTN_ADD];
  assign sub   = btn_pulse[BTN_SUB];
  assign clear = btn_pulse[BTN_CLEAR];

  calc_alu u_alu (
    .a       (op_a_q),
    .b       (op_b_q),
    .add_sub (add_sub_q),
    .res     (alu_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= GET_A;
      op_a_q    <= 8'd0;
      op_b_q    <= 8'd0;
      add_sub_q <= 1'b0;
      result_q  <= 16'd0;
      sign_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      add_sub_q <= add_sub_d;
      result_q  <= result_d;
      sign_q    <= sign_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    add_sub_d = add_sub_q;
    result_d  = result_q;
    sign_d    = sign_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    start_c   = 1'b0;

    if (clear) begin
      state_d   = GET_A;
      op_a_d    = 8'd0;
      op_b_d    = 8'd0;
      add_sub_d = 1'b0;
      result_d  = 16'd0;
      sign_d    = 1'b0;
      err_d     = 1'b0;
      cnt_d     = '0;
    end else begin
      unique case (state_q)
        GET_A: begin
          if (enter) begin
            op_a_d  = sw;
            state_d = GET_B;
          end
        end
        GET_B: begin
          if (enter) begin
            op_b_d  = sw;
            state_d = GET_OP;
          end
        end
        GET_OP: begin
          if (add) begin
            add_sub_d = 1'b0;
            state_d   = CALC;
          end else if (sub) begin
            add_sub_d = 1'b1;
            state_d   = CALC;
          end
        end
        CALC: begin
          result_d = alu_res.mag;
          sign_d   = alu_res.sign;
          state_d  = START;
        end
        START: begin
          if (!conv_busy) begin
            start_c = 1'b1;
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
        WAIT: begin
          // done on the final counted cycle still wins over timeout
          if (conv_done) begin
            state_d = SHOW;
          end else if (cnt_q == CNT_LAST) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SHOW: begin
          if (enter) begin
            state_d = GET_A;
          end else if (add) begin
            add_sub_d = 1'b0;
            state_d   = CALC;
          end else if (sub) begin
            add_sub_d = 1'b1;
            state_d   = CALC;
          end
        end
        ERR: begin
          state_d = ERR;
        end
        default: begin
          state_d = GET_A;
        end
      endcase
    end
  end

  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign add_sub    = add_sub_q;
  assign result     = result_q;
  assign sign       = sign_q;
  assign err        = err_q;
  assign state      = state_q;
  assign conv_start = start_c;
  assign disp_valid = (state_q == SHOW);

endmodule

// File: doc/calc_seq_ctrl.md
CALC_SEQ_CTRL -- requirements
Module: calc_seq_ctrl

Interface
REQ-001 The block SHALL have parameter CONV_TIMEOUT, default 64, the maximum clk cycles it waits in WAIT for conv_done.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port btn_pulse, input, 4 bits: debounced one-cycle pulses; [0]=enter, [1]=add, [2]=sub, [3]=clear.
REQ-005 The block SHALL have port sw, input, 8 bits: unsigned operand source.
REQ-006 The block SHALL have port conv_busy, input, 1 bit: the BCD converter cannot accept a start.
REQ-007 The block SHALL have port conv_done, input, 1 bit: a one-cycle pulse when the converter finishes.
REQ-008 The block SHALL have port op_a, output, 8 bits, and port op_b, output, 8 bits: the latched operands.
REQ-009 The block SHALL have port add_sub, output, 1 bit: 0=add, 1=subtract.
REQ-010 The block SHALL have port result, output, 16 bits: the magnitude of the result, zero-extended, fed to the converter.
REQ-011 The block SHALL have port sign, output, 1 bit: 1 when the result is negative.
REQ-012 The block SHALL have port conv_start, output, 1 bit: a one-cycle start pulse to the converter.
REQ-013 The block SHALL have port disp_valid, output, 1 bit, port err, output, 1 bit, and port state, output, 3 bits: the state code.

Function
REQ-014 The FSM SHALL have the states GET_A, GET_B, GET_OP, CALC, START, WAIT, SHOW and ERR.
REQ-015 In GET_A, enter SHALL latch sw into op_a and move to GET_B; in GET_B, enter SHALL latch sw into op_b and move to GET_OP.
REQ-016 In GET_OP, add SHALL set add_sub=0 and sub SHALL set add_sub=1, and either SHALL move to CALC; if add and sub arrive together, add SHALL win.
REQ-017 CALC SHALL last exactly one cycle and register the result, then move to START.
REQ-018 For add, the block SHALL set result = op_a + op_b (0..510) and sign = 0.
REQ-019 For subtract, the block SHALL set result = |op_a - op_b| and sign = (op_b > op_a); an equal-operand subtract SHALL give result 0 and sign 0.
REQ-020 In START, conv_start SHALL pulse for one cycle on the first cycle with conv_busy=0, followed by a move to WAIT; while conv_busy=1, the block SHALL stay in START with no pulse.
REQ-021 In WAIT, the timeout counter SHALL count clk cycles from 0; conv_done SHALL move the FSM to SHOW.
REQ-022 If the counter reaches CONV_TIMEOUT without conv_done, the FSM SHALL enter ERR and set err=1.
REQ-023 disp_valid SHALL be 1 only in SHOW.
REQ-024 In SHOW, enter SHALL go to GET_A with the operands kept until overwritten; add or sub SHALL update add_sub and go to CALC, recomputing on the same operands.
REQ-025 In ERR, only clear SHALL be accepted; all other buttons SHALL be ignored.
REQ-026 Clear SHALL act from any state, go to GET_A, and zero op_a, op_b, add_sub, result, sign and err; clear SHALL override any other button in the same cycle.
REQ-027 conv_done SHALL be ignored outside WAIT, including a late done after a clear or timeout.
REQ-028 Button pulses SHALL be ignored in CALC, START and WAIT, except clear.

Reset
REQ-029 rst=1 SHALL asynchronously force state=GET_A and all outputs to 0, and SHALL clear the timeout counter.
REQ-030 Reset during START or WAIT SHALL abort with no further conv_start.
REQ-031 After rst is released, the block SHALL act on the first clk edge.

Structure
REQ-032 Package calc_pkg SHALL hold the state encoding (GET_A=0 ... ERR=7), the button index constants and the CONV_TIMEOUT default.
REQ-033 Sub-module calc_alu SHALL compute the magnitude and sign from op_a, op_b and add_sub; the FSM and the timeout counter SHALL stay in calc_seq_ctrl.

Verification
REQ-034 Scenario: sw=25, enter; sw=100, enter; add; converter done after 10 cycles -> result=125, sign=0, disp_valid=1.
REQ-035 Scenario: operands 20 and 45, then sub -> result=25, sign=1; then press add in SHOW -> result=65, sign=0, one new conv_start.
REQ-036 Scenario: operands 255 and 255 with add -> result=510; with sub -> result=0, sign=0.
REQ-037 Scenario: conv_busy held at 1 for 5 cycles in START -> no pulse during those cycles, then exactly one conv_start.
REQ-038 Scenario: conv_done never arrives -> ERR with err=1 after 64 WAIT cycles; enter is ignored; clear returns to GET_A with err=0.
REQ-039 Scenario: clear in WAIT followed by a late conv_done -> state GET_A, disp_valid=0; also enter and clear in the same cycle -> clear wins.
